clk_sel_ctrl: RTL and testbench



---
 rtl/clk_sel_ctrl_if.sv | 50 +++++
 rtl/clk_sel_ctrl.sv | 136 +++++++++++++
 tb/tb_clk_sel_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/clk_sel_ctrl_if.sv
// clk_sel_ctrl_if: request/ready handshake plus enable/status bundle between a requester and clk_sel_ctrl.
// Latency: none, wires only.
// Backpressure: sel_ready_o qualifies sel_valid_i; the requester holds sel_i/sel_valid_i until ready.
// Optional CLK_SEL_ACK_EN adds src_ack_i, gate-status acks already synchronised into the reference clock.
interface clk_sel_ctrl_if #(
    parameter int NUM_CLK = 4,
    parameter int SEL_W   = $clog2(NUM_CLK)
);
    logic [SEL_W-1:0]   sel_i;
    logic               sel_valid_i;
    logic               sel_ready_o;
    logic [NUM_CLK-1:0] clk_en_o;
    logic [SEL_W-1:0]   active_sel_o;
    logic               busy_o;
    logic               switch_done_o;
    logic               err_o;
`ifdef CLK_SEL_ACK_EN
    logic [NUM_CLK-1:0] src_ack_i;
`endif

    // Requester / gate-status side
    modport master (
        output sel_i,
        output sel_valid_i,
`ifdef CLK_SEL_ACK_EN
        output src_ack_i,
`endif
        input  sel_ready_o,
        input  clk_en_o,
        input  active_sel_o,
        input  busy_o,
        input  switch_done_o,
        input  err_o
    );

    // Controller side
    modport slave (
        input  sel_i,
        input  sel_valid_i,
`ifdef CLK_SEL_ACK_EN
        input  src_ack_i,
`endif
        output sel_ready_o,
        output clk_en_o,
        output active_sel_o,
        output busy_o,
        output switch_done_o,
        output err_o
    );
endinterface

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: break-before-make one-hot clock-gate enable controller for NUM_CLK sources.
// Latency: a switch takes 2*SETTLE_CYC cycles then a done pulse; same-source/error responses next cycle.
// Backpressure: sel_ready_o is low while a switch is in flight; held requests wait for ready.
// Optional CLK_SEL_ACK_EN: phase exits additionally wait for the synchronised gate acks on src_ack_i.
module clk_sel_ctrl #(
    parameter int NUM_CLK     = 4,
    parameter int SEL_W       = $clog2(NUM_CLK),
    parameter int DEFAULT_SEL = 0,
    parameter int SETTLE_CYC  = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    clk_sel_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        GATE_ON  = 2'd2
    } state_e;

    localparam int                 CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    // Loading SETTLE_CYC-1 and exiting on the edge that sees zero gives exactly SETTLE_CYC cycles per phase.
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0]   DEF_SEL  = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_CLK-1:0] DEF_EN   = NUM_CLK'(1) << DEFAULT_SEL;

    function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_CLK'(1) << idx;
    endfunction

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [NUM_CLK-1:0] en_q,     en_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;

    logic               in_range;
    logic               off_ok;
    logic               on_ok;
    logic [SEL_W:0]     sel_ext;

    assign sel_ext  = {1'b0, bus.sel_i};
    assign in_range = (int'(sel_ext) < NUM_CLK);

`ifdef CLK_SEL_ACK_EN
    // Gates must report fully off before any new enable, and the new source must report on before done.
    assign off_ok = (bus.src_ack_i == '0);
    assign on_ok  = bus.src_ack_i[target_q];
`else
    assign off_ok = 1'b1;
    assign on_ok  = 1'b1;
`endif

    // State register: all outputs except ready/busy come straight from these flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= DEF_SEL;
            active_q <= DEF_SEL;
            en_q     <= DEF_EN;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            active_q <= active_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state: accept in IDLE, drop all enables, settle, enable target, settle, report done
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        active_d = active_q;
        en_d     = en_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sel_valid_i) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (bus.sel_i == active_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = bus.sel_i;
                        cnt_d    = CNT_LOAD;
                        en_d     = '0;
                        state_d  = GATE_OFF;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (off_ok) begin
                    cnt_d    = CNT_LOAD;
                    en_d     = onehot(target_q);
                    active_d = target_q;
                    state_d  = GATE_ON;
                end
            end
            GATE_ON: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (on_ok) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: handshake and busy decode from state only
    always_comb begin
        bus.sel_ready_o = (state_q == IDLE);
        bus.busy_o      = (state_q != IDLE);
    end

    assign bus.clk_en_o      = en_q;
    assign bus.active_sel_o  = active_q;
    assign bus.switch_done_o = done_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed plus randomized requests against a transaction-level model of the controller.
// Latency: expected per-cycle outputs derived from the switch timeline (SETTLE_CYC off, SETTLE_CYC on, done).
// Backpressure: requests are only issued when the model says the controller is idle; busy-time requests are noise.
module tb_clk_sel_ctrl;
    localparam int NC = 5;
    localparam int SW = $clog2(NC);
    localparam int S  = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_active;
    bit   mon_en      = 1'b0;
    logic [NC-1:0] prev_en = '0;

    clk_sel_ctrl_if #(.NUM_CLK(NC), .SEL_W(SW)) bus ();

    clk_sel_ctrl #(
        .NUM_CLK    (NC),
        .SEL_W      (SW),
        .DEFAULT_SEL(0),
        .SETTLE_CYC (S)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NC-1:0] oh(input int idx);
        logic [NC-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ph, input logic [NC-1:0] en, input int act,
                           input bit rdy, input bit busy, input bit done, input bit err);
        chk({ph, ".clk_en"}, 32'(bus.clk_en_o), 32'(en));
        chk({ph, ".active"}, 32'(bus.active_sel_o), 32'(act));
        chk({ph, ".ready"},  32'(bus.sel_ready_o), 32'(rdy));
        chk({ph, ".busy"},   32'(bus.busy_o), 32'(busy));
        chk({ph, ".done"},   32'(bus.switch_done_o), 32'(done));
        chk({ph, ".err"},    32'(bus.err_o), 32'(err));
    endtask

    task automatic noise_drive(input bit noise);
        if (noise) begin
            bus.sel_valid_i = 1'($urandom_range(0, 1));
            bus.sel_i       = SW'($urandom_range(0, (1 << SW) - 1));
        end else begin
            bus.sel_valid_i = 1'b0;
        end
    endtask

    // Issue one request from an idle negedge; returns at the negedge of the response/done cycle.
    task automatic request(input int sel, input int off_extra, input bit noise);
        bus.sel_i       = SW'(sel);
        bus.sel_valid_i = 1'b1;
        @(negedge clk);
        bus.sel_valid_i = 1'b0;
        if (sel >= NC) begin
            chk_all("err", oh(m_active), m_active, 1'b1, 1'b0, 1'b0, 1'b1);
        end else if (sel == m_active) begin
            chk_all("same", oh(m_active), m_active, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            for (int k = 1; k <= S + off_extra; k++) begin
                chk_all("off", '0, m_active, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef CLK_SEL_ACK_EN
                if (k >= S + off_extra) bus.src_ack_i = '0;
`endif
                noise_drive(noise);
                @(negedge clk);
            end
            m_active = sel;
            for (int k = 1; k <= S; k++) begin
                chk_all("on", oh(m_active), m_active, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef CLK_SEL_ACK_EN
                bus.src_ack_i = oh(m_active);
`endif
                noise_drive(noise);
                @(negedge clk);
            end
            chk_all("done", oh(m_active), m_active, 1'b1, 1'b0, 1'b1, 1'b0);
            bus.sel_valid_i = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        bus.sel_valid_i = 1'b0;
        @(negedge clk);
        chk_all("idle", oh(m_active), m_active, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Enables must be one-hot-or-zero and never hop directly between two sources
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("onehot0", 32'($onehot0(bus.clk_en_o)), 32'd1);
            chk("break_before_make",
                32'((prev_en != '0) && (bus.clk_en_o != '0) && (prev_en != bus.clk_en_o)), 32'd0);
        end
        prev_en = bus.clk_en_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int sel;
        int r;
        int extra;
        rst             = 1'b1;
        bus.sel_i       = '0;
        bus.sel_valid_i = 1'b0;
`ifdef CLK_SEL_ACK_EN
        bus.src_ack_i   = oh(0);
`endif
        m_active        = 0;

        // Reset held two cycles
        repeat (2) begin
            @(negedge clk);
            chk_all("reset", oh(0), 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        idle_cycle();

        // 0 -> 2 with ignored busy-time requests, then back-to-back same-source request in the done cycle
        request(2, 0, 1'b1);
        request(2, 0, 1'b0);
        idle_cycle();

        // Out-of-range selects
        request(6, 0, 1'b0);
        request(5, 0, 1'b0);
        idle_cycle();
        request(7, 0, 1'b0);
        idle_cycle();

        // Reset abandons a 2 -> 3 switch part-way through the all-off phase
        bus.sel_i       = SW'(3);
        bus.sel_valid_i = 1'b1;
        @(negedge clk);
        bus.sel_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk_all("rst_mid.off", '0, m_active, 1'b0, 1'b1, 1'b0, 1'b0);
            if (k < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        m_active = 0;
`ifdef CLK_SEL_ACK_EN
        bus.src_ack_i = oh(0);
`endif
        chk_all("rst_mid", oh(0), 0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycle();
        idle_cycle();

`ifdef CLK_SEL_ACK_EN
        // Old gate ack lingers 5 cycles past counter expiry
        request(1, 5, 1'b0);
        idle_cycle();
`endif

        // Randomized sequence of requests, gaps and back-to-back issues
        repeat (40) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      sel = m_active;
            else if (r < 3) sel = int'($urandom_range(NC, (1 << SW) - 1));
            else            sel = int'($urandom_range(0, NC - 1));
`ifdef CLK_SEL_ACK_EN
            extra = int'($urandom_range(0, 3));
`else
            extra = 0;
`endif
            request(sel, extra, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
